// File: rtl/register_file.sv
// SM83 architectural register file: IR, IE, A, F, B/C/D/E/H/L, PC and SP.
// Synchronous writes, combinational reads, asynchronous active-low reset.
`default_nettype none

module register_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  wen,
  input  logic [7:0]  w_ir,
  input  logic [7:0]  w_ie,
  input  logic [7:0]  w_a,
  input  logic [7:0]  w_f,
  input  logic [2:0]  w_sel8_gp,
  input  logic [7:0]  w8_gp,
  input  logic [1:0]  w_sel16_gp,
  input  logic [15:0] w16_gp,
  input  logic [15:0] w_pc,
  input  logic [15:0] w_sp,
  output logic [7:0]  r_ir,
  output logic [7:0]  r_ie,
  output logic [7:0]  r_a,
  output logic [7:0]  r_f,
  input  logic [2:0]  r_sel8_gp,
  output logic [7:0]  r8_gp,
  input  logic [1:0]  r_sel16_gp,
  output logic [15:0] r16_gp,
  output logic [15:0] r_pc,
  output logic [15:0] r_sp
);

  localparam int WEN_IR   = 0;
  localparam int WEN_IE   = 1;
  localparam int WEN_A    = 2;
  localparam int WEN_F    = 3;
  localparam int WEN_GP8  = 4;
  localparam int WEN_GP16 = 5;
  localparam int WEN_PC   = 6;
  localparam int WEN_SP   = 7;

  localparam int NUM_GP = 6;

  logic [7:0]  ir_q;
  logic [7:0]  ie_q;
  logic [7:0]  a_q;
  logic [3:0]  f_hi_q;
  logic [15:0] pc_q;
  logic [15:0] sp_q;

  // Byte i of this bus is GP register i (B, C, D, E, H, L).
  logic [8*NUM_GP-1:0] gp_bus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q   <= 8'h00;
      ie_q   <= 8'h00;
      a_q    <= 8'h00;
      f_hi_q <= 4'h0;
      pc_q   <= 16'h0000;
      sp_q   <= 16'h0000;
    end else begin
      if (wen[WEN_IR]) ir_q   <= w_ir;
      if (wen[WEN_IE]) ie_q   <= w_ie;
      if (wen[WEN_A])  a_q    <= w_a;
      if (wen[WEN_F])  f_hi_q <= w_f[7:4];
      if (wen[WEN_PC]) pc_q   <= w_pc;
      if (wen[WEN_SP]) sp_q   <= w_sp;
    end
  end

  for (genvar i = 0; i < NUM_GP; i++) begin : g_gp
    localparam logic [2:0] SEL8  = 3'(i);
    localparam logic [1:0] SEL16 = 2'(i / 2);
    localparam bit         IS_HI = ((i % 2) == 0);

    logic       hit8;
    logic       hit16;
    logic [7:0] pair_byte;
    logic [7:0] d;
    logic [7:0] q;

    assign hit8      = wen[WEN_GP8]  && (w_sel8_gp  == SEL8);
    assign hit16     = wen[WEN_GP16] && (w_sel16_gp == SEL16);
    assign pair_byte = IS_HI ? w16_gp[15:8] : w16_gp[7:0];
    // A byte-wide write takes priority over the pair write on the same byte.
    assign d         = hit8 ? w8_gp : pair_byte;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= 8'h00;
      end else if (hit8 || hit16) begin
        q <= d;
      end
    end

    assign gp_bus[8*i +: 8] = q;
  end

  assign r_ir = ir_q;
  assign r_ie = ie_q;
  assign r_a  = a_q;
  assign r_f  = {f_hi_q, 4'h0};
  assign r_pc = pc_q;
  assign r_sp = sp_q;

  always_comb begin
    r8_gp = 8'h00;
    case (r_sel8_gp)
      3'd0:    r8_gp = gp_bus[7:0];
      3'd1:    r8_gp = gp_bus[15:8];
      3'd2:    r8_gp = gp_bus[23:16];
      3'd3:    r8_gp = gp_bus[31:24];
      3'd4:    r8_gp = gp_bus[39:32];
      3'd5:    r8_gp = gp_bus[47:40];
      default: r8_gp = 8'h00;
    endcase
  end

  always_comb begin
    r16_gp = 16'h0000;
    case (r_sel16_gp)
      2'd0:    r16_gp = {gp_bus[7:0],   gp_bus[15:8]};
      2'd1:    r16_gp = {gp_bus[23:16], gp_bus[31:24]};
      2'd2:    r16_gp = {gp_bus[39:32], gp_bus[47:40]};
      default: r16_gp = 16'h0000;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file.
`default_nettype none

module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [7:0]  wen;
  logic [7:0]  w_ir, w_ie, w_a, w_f;
  logic [2:0]  w_sel8_gp;
  logic [7:0]  w8_gp;
  logic [1:0]  w_sel16_gp;
  logic [15:0] w16_gp;
  logic [15:0] w_pc, w_sp;
  logic [7:0]  r_ir, r_ie, r_a, r_f;
  logic [2:0]  r_sel8_gp;
  logic [7:0]  r8_gp;
  logic [1:0]  r_sel16_gp;
  logic [15:0] r16_gp;
  logic [15:0] r_pc, r_sp;

  int checks = 0;
  int errors = 0;

  register_file dut (
    .clk(clk), .rst_n(rst_n), .wen(wen),
    .w_ir(w_ir), .w_ie(w_ie), .w_a(w_a), .w_f(w_f),
    .w_sel8_gp(w_sel8_gp), .w8_gp(w8_gp),
    .w_sel16_gp(w_sel16_gp), .w16_gp(w16_gp),
    .w_pc(w_pc), .w_sp(w_sp),
    .r_ir(r_ir), .r_ie(r_ie), .r_a(r_a), .r_f(r_f),
    .r_sel8_gp(r_sel8_gp), .r8_gp(r8_gp),
    .r_sel16_gp(r_sel16_gp), .r16_gp(r16_gp),
    .r_pc(r_pc), .r_sp(r_sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  wen;
    logic [7:0]  ir, ie, a, f;
    logic [2:0]  s8;
    logic [7:0]  d8;
    logic [1:0]  s16;
    logic [15:0] d16, pc, sp;
    logic [2:0]  rs8;
    logic [1:0]  rs16;
    logic [7:0]  e_ir, e_ie, e_a, e_f, e_r8;
    logic [15:0] e_r16, e_pc, e_sp;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_zero(input int idx);
    check("zero_ir",  idx, {8'h00, r_ir}, 16'h0);
    check("zero_ie",  idx, {8'h00, r_ie}, 16'h0);
    check("zero_a",   idx, {8'h00, r_a},  16'h0);
    check("zero_f",   idx, {8'h00, r_f},  16'h0);
    check("zero_r8",  idx, {8'h00, r8_gp}, 16'h0);
    check("zero_r16", idx, r16_gp, 16'h0);
    check("zero_pc",  idx, r_pc, 16'h0);
    check("zero_sp",  idx, r_sp, 16'h0);
  endtask

  task automatic drive_random();
    wen        = 8'($urandom);
    w_ir       = 8'($urandom);
    w_ie       = 8'($urandom);
    w_a        = 8'($urandom);
    w_f        = 8'($urandom);
    w_sel8_gp  = 3'($urandom);
    w8_gp      = 8'($urandom);
    w_sel16_gp = 2'($urandom);
    w16_gp     = 16'($urandom);
    w_pc       = 16'($urandom);
    w_sp       = 16'($urandom);
  endtask

  initial begin
    // Field order: wen, ir, ie, a, f, s8, d8, s16, d16, pc, sp, rs8, rs16,
    //              e_ir, e_ie, e_a, e_f, e_r8, e_r16, e_pc, e_sp
    vecs[0]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 2'd0,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{8'hCF, 8'h3C, 8'h1F, 8'hA5, 8'hFF, 3'd0, 8'h00, 2'd0, 16'h0000, 16'h0100, 16'hFFFE, 3'd0, 2'd0,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'h00, 16'h0000, 16'h0100, 16'hFFFE};
    vecs[2]  = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h12, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 2'd0,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'h12, 16'h1200, 16'h0100, 16'hFFFE};
    vecs[3]  = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 8'h34, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd1, 2'd0,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'h34, 16'h1234, 16'h0100, 16'hFFFE};
    vecs[4]  = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2, 8'h56, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd2, 2'd1,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'h56, 16'h5600, 16'h0100, 16'hFFFE};
    vecs[5]  = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 3'd3, 8'h78, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd3, 2'd1,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'h78, 16'h5678, 16'h0100, 16'hFFFE};
    vecs[6]  = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 3'd4, 8'h9A, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd4, 2'd2,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'h9A, 16'h9A00, 16'h0100, 16'hFFFE};
    vecs[7]  = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 3'd5, 8'hBC, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd5, 2'd2,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'hBC, 16'h9ABC, 16'h0100, 16'hFFFE};
    vecs[8]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd6, 2'd1,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'h00, 16'h5678, 16'h0100, 16'hFFFE};
    vecs[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd7, 2'd3,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'h00, 16'h0000, 16'h0100, 16'hFFFE};
    vecs[10] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 2'd2, 16'hC0DE, 16'h0000, 16'h0000, 3'd4, 2'd2,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'hC0, 16'hC0DE, 16'h0100, 16'hFFFE};
    vecs[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd5, 2'd2,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'hDE, 16'hC0DE, 16'h0100, 16'hFFFE};
    vecs[12] = '{8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 3'd6, 8'h77, 2'd3, 16'h1111, 16'h0000, 16'h0000, 3'd0, 2'd0,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'h12, 16'h1234, 16'h0100, 16'hFFFE};
    vecs[13] = '{8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 3'd7, 8'h77, 2'd3, 16'h2222, 16'h0000, 16'h0000, 3'd3, 2'd1,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'h78, 16'h5678, 16'h0100, 16'hFFFE};
    vecs[14] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd4, 2'd2,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'hC0, 16'hC0DE, 16'h0100, 16'hFFFE};
    vecs[15] = '{8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 8'h55, 2'd0, 16'hAAAA, 16'h0000, 16'h0000, 3'd0, 2'd0,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'hAA, 16'hAA55, 16'h0100, 16'hFFFE};
    vecs[16] = '{8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 3'd4, 8'h11, 2'd1, 16'hBEEF, 16'h0000, 16'h0000, 3'd2, 2'd2,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'hBE, 16'h11DE, 16'h0100, 16'hFFFE};
    vecs[17] = '{8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 3'd4, 8'h44, 2'd2, 16'h2233, 16'h0000, 16'h0000, 3'd3, 2'd2,
                 8'h3C, 8'h1F, 8'hA5, 8'hF0, 8'hEF, 16'h4433, 16'h0100, 16'hFFFE};
    vecs[18] = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h9A, 3'd5, 8'h66, 2'd0, 16'h0102, 16'h1234, 16'h5678, 3'd5, 2'd0,
                 8'h01, 8'h02, 8'h03, 8'h90, 8'h66, 16'h0102, 16'h1234, 16'h5678};
    vecs[19] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h0F, 3'd0, 8'h00, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd4, 2'd1,
                 8'h01, 8'h02, 8'h03, 8'h00, 8'h44, 16'hBEEF, 16'h1234, 16'h5678};
    vecs[20] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 2'd0, 16'h0000, 16'hABCD, 16'h0000, 3'd1, 2'd2,
                 8'h01, 8'h02, 8'h03, 8'h00, 8'h02, 16'h4466, 16'hABCD, 16'h5678};
    vecs[21] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 2'd0, 16'h0000, 16'h0000, 16'h1357, 3'd0, 2'd1,
                 8'h01, 8'h02, 8'h03, 8'h00, 8'h01, 16'hBEEF, 16'hABCD, 16'h1357};
    vecs[22] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2, 8'h00, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd2, 2'd0,
                 8'h01, 8'h02, 8'h03, 8'h00, 8'hBE, 16'h0102, 16'hABCD, 16'h1357};

    // Reset held with random writes, then released with writes disabled.
    rst_n      = 1'b0;
    r_sel8_gp  = 3'd0;
    r_sel16_gp = 2'd0;
    drive_random();
    #1 check_zero(-1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_random();
      r_sel8_gp  = 3'($urandom);
      r_sel16_gp = 2'($urandom);
      @(posedge clk);
      #1 check_zero(c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wen   = 8'h00;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      wen        = 8'h00;
      r_sel8_gp  = 3'(c % 8);
      r_sel16_gp = 2'(c % 4);
      @(posedge clk);
      #1 check_zero(100 + c);
    end

    // Table-driven writes; disabled data inputs carry random junk.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_random();
      wen        = vecs[i].wen;
      if (wen[0]) w_ir = vecs[i].ir;
      if (wen[1]) w_ie = vecs[i].ie;
      if (wen[2]) w_a  = vecs[i].a;
      if (wen[3]) w_f  = vecs[i].f;
      if (wen[4]) begin w_sel8_gp  = vecs[i].s8;  w8_gp  = vecs[i].d8;  end
      if (wen[5]) begin w_sel16_gp = vecs[i].s16; w16_gp = vecs[i].d16; end
      if (wen[6]) w_pc = vecs[i].pc;
      if (wen[7]) w_sp = vecs[i].sp;
      r_sel8_gp  = vecs[i].rs8;
      r_sel16_gp = vecs[i].rs16;
      @(posedge clk);
      #1;
      check("ir",  i, {8'h00, r_ir},  {8'h00, vecs[i].e_ir});
      check("ie",  i, {8'h00, r_ie},  {8'h00, vecs[i].e_ie});
      check("a",   i, {8'h00, r_a},   {8'h00, vecs[i].e_a});
      check("f",   i, {8'h00, r_f},   {8'h00, vecs[i].e_f});
      check("r8",  i, {8'h00, r8_gp}, {8'h00, vecs[i].e_r8});
      check("r16", i, r16_gp, vecs[i].e_r16);
      check("pc",  i, r_pc, vecs[i].e_pc);
      check("sp",  i, r_sp, vecs[i].e_sp);
    end

    // No bypass: write to A is invisible until the edge.
    @(negedge clk);
    wen = 8'h04;
    w_a = 8'h5A;
    #1 check("a_before_edge", 0, {8'h00, r_a}, 16'h0003);
    @(posedge clk);
    #1 check("a_after_edge", 0, {8'h00, r_a}, 16'h005A);

    // Read selects act combinationally mid-cycle.
    @(negedge clk);
    wen = 8'h00;
    r_sel8_gp = 3'd5;
    #1 check("comb_r8", 0, {8'h00, r8_gp}, 16'h0066);
    r_sel8_gp = 3'd3;
    #1 check("comb_r8", 1, {8'h00, r8_gp}, 16'h00EF);
    r_sel16_gp = 2'd2;
    #1 check("comb_r16", 0, r16_gp, 16'h4466);
    r_sel16_gp = 2'd1;
    #1 check("comb_r16", 1, r16_gp, 16'hBEEF);

    // Asynchronous reset between edges, with a write pending that must be lost.
    @(negedge clk);
    drive_random();
    wen = 8'hFF;
    w_sel8_gp  = 3'd4;
    w_sel16_gp = 2'd2;
    r_sel8_gp  = 3'd4;
    r_sel16_gp = 2'd2;
    #2 rst_n = 1'b0;
    #1 check_zero(300);
    @(posedge clk);
    #1 check_zero(301);
    @(negedge clk);
    rst_n = 1'b1;
    wen   = 8'h00;
    @(posedge clk);
    #1 check_zero(302);

    // Registers still load normally after a mid-run reset.
    @(negedge clk);
    wen  = 8'h40;
    w_pc = 16'h0150;
    @(posedge clk);
    #1 check("pc_after_reset", 0, r_pc, 16'h0150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
